// File: rtl/sdram_bist_engine.sv
// Memory BIST: writes a pattern over NUM_WORDS words, reads it back and compares.
// Define SDRAM_BIST_LFSR_EN to build mode 3 as a 32-bit LFSR pattern; otherwise mode 3 repeats mode 0.
module sdram_bist_engine #(
  parameter int              DATA_W      = 16,
  parameter int              ADDR_W      = 32,
  parameter longint unsigned BASE_ADDR   = 0,
  parameter int              ADDR_STEP   = 2,
  parameter int              NUM_WORDS   = 1024,
  parameter int              START_DELAY = 100000000,
  parameter int              TIMEOUT     = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [15:0]       error_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_expected,
  output logic [DATA_W-1:0] fail_actual,
  output logic              writeport_wr,
  output logic [ADDR_W-1:0] writeport_addr,
  output logic [DATA_W-1:0] writeport_data,
  input  logic              writeport_ack,
  output logic              readport_rd,
  output logic [ADDR_W-1:0] readport_addr,
  input  logic [DATA_W-1:0] readport_data,
  input  logic              readport_ack,
  output logic [2:0]        state
);
  // Handshake: wr/rd high with stable addr/data is a pending request; the port completes
  // it by driving ack high for a sampled cycle, the request drops the next cycle, and
  // acks seen while nothing is pending are ignored. Only one request is ever in flight.
  localparam logic [31:0]       LFSR_SEED  = 32'hACE10001;
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(ADDR_STEP);
  localparam logic [31:0]       LAST_IDX   = 32'(NUM_WORDS - 1);
  localparam logic [5:0]        LAST_POS   = 6'(DATA_W - 1);
  localparam logic [31:0]       DELAY_LAST = 32'(START_DELAY - 1);
  localparam logic [31:0]       WAIT_LIMIT = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DELAY   = 3'd1,
    WR_REQ  = 3'd2,
    WR_WAIT = 3'd3,
    RD_REQ  = 3'd4,
    RD_WAIT = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t            st;
  logic [31:0]       index;
  logic [31:0]       dly_cnt;
  logic [31:0]       wait_cnt;
  logic [5:0]        bit_pos;
  logic [ADDR_W-1:0] cur_addr;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] pattern;
  logic              last_word;
  logic [31:0]       index_next;
  logic [5:0]        bit_pos_next;
  logic [ADDR_W-1:0] addr_next;

  assign state        = st;
  assign pass         = done & (error_count == 16'd0) & ~timeout;
  assign fail         = done & ~pass;
  assign last_word    = (index == LAST_IDX);
  assign index_next   = index + 32'd1;
  // bit_pos tracks index mod DATA_W so the walking-one pattern needs no divider
  assign bit_pos_next = (bit_pos == LAST_POS) ? 6'd0 : bit_pos + 6'd1;
  assign addr_next    = cur_addr + STEP;

`ifdef SDRAM_BIST_LFSR_EN
  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  assign lfsr_next = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

  // Reseeded for the read pass so the read side regenerates the written sequence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if ((st == IDLE || st == DONE) && start) begin
      lfsr <= LFSR_SEED;
    end else if (st == WR_WAIT && writeport_ack) begin
      lfsr <= last_word ? LFSR_SEED : lfsr_next;
    end else if (st == RD_WAIT && readport_ack) begin
      lfsr <= lfsr_next;
    end
  end
`endif

  always_comb begin
    pattern = index[DATA_W-1:0];
    case (mode_q)
      2'd1: pattern = ~index[DATA_W-1:0];
      2'd2: pattern = DATA_W'(1) << bit_pos;
`ifdef SDRAM_BIST_LFSR_EN
      2'd3: pattern = lfsr[DATA_W-1:0];
`else
      2'd3: pattern = index[DATA_W-1:0];
`endif
      default: pattern = index[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st             <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      error_count    <= 16'd0;
      fail_addr      <= '0;
      fail_expected  <= '0;
      fail_actual    <= '0;
      writeport_wr   <= 1'b0;
      writeport_addr <= '0;
      writeport_data <= '0;
      readport_rd    <= 1'b0;
      readport_addr  <= '0;
      index          <= '0;
      bit_pos        <= '0;
      cur_addr       <= '0;
      dly_cnt        <= '0;
      wait_cnt       <= '0;
      mode_q         <= '0;
    end else begin
      case (st)
        IDLE, DONE: begin
          if (start) begin
            busy          <= 1'b1;
            done          <= 1'b0;
            timeout       <= 1'b0;
            error_count   <= 16'd0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
            index         <= '0;
            bit_pos       <= '0;
            cur_addr      <= BASE;
            dly_cnt       <= '0;
            mode_q        <= mode;
            st            <= (START_DELAY == 0) ? WR_REQ : DELAY;
          end
        end
        DELAY: begin
          if (dly_cnt == DELAY_LAST) st <= WR_REQ;
          else dly_cnt <= dly_cnt + 32'd1;
        end
        WR_REQ: begin
          writeport_wr   <= 1'b1;
          writeport_addr <= cur_addr;
          writeport_data <= pattern;
          wait_cnt       <= '0;
          st             <= WR_WAIT;
        end
        WR_WAIT: begin
          if (writeport_ack) begin
            writeport_wr <= 1'b0;
            if (last_word) begin
              index    <= '0;
              bit_pos  <= '0;
              cur_addr <= BASE;
              st       <= RD_REQ;
            end else begin
              index    <= index_next;
              bit_pos  <= bit_pos_next;
              cur_addr <= addr_next;
              st       <= WR_REQ;
            end
          end else if (wait_cnt == WAIT_LIMIT) begin
            writeport_wr <= 1'b0;
            timeout      <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
            st           <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        RD_REQ: begin
          readport_rd   <= 1'b1;
          readport_addr <= cur_addr;
          wait_cnt      <= '0;
          st            <= RD_WAIT;
        end
        RD_WAIT: begin
          if (readport_ack) begin
            readport_rd <= 1'b0;
            if (readport_data != pattern) begin
              if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
              if (error_count == 16'd0) begin
                fail_addr     <= readport_addr;
                fail_expected <= pattern;
                fail_actual   <= readport_data;
              end
            end
            if (last_word) begin
              busy <= 1'b0;
              done <= 1'b1;
              st   <= DONE;
            end else begin
              index    <= index_next;
              bit_pos  <= bit_pos_next;
              cur_addr <= addr_next;
              st       <= RD_REQ;
            end
          end else if (wait_cnt == WAIT_LIMIT) begin
            readport_rd <= 1'b0;
            timeout     <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            st          <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_bist_engine.sv
// Directed bench for sdram_bist_engine: a 4-word and an 18-word instance, each on a one-cycle-ack memory model.
module tb_sdram_bist_engine;
  localparam int DW  = 16;
  localparam int AW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] start = 2'b00;
  logic [1:0] busy, done, pass, fail, tmo, wr, wack, rd, rack;
  logic [1:0][15:0] ecnt, fexp, fact, wdata, rdata;
  logic [1:0][31:0] faddr, waddr, raddr;
  logic [1:0][2:0]  st;

  logic        block_wr = 1'b0;
  logic [31:0] corrupt_mask = 32'd0;
  logic [15:0] corrupt_val = 16'h00FF;
  logic        overlap_seen = 1'b0;
  logic [31:0] wr_log_q[$];
  logic [15:0] mem [0:1][0:31];

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sdram_bist_engine #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(0), .ADDR_STEP(2),
                      .NUM_WORDS(4), .START_DELAY(3), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst(rst), .start(start[0]), .mode(mode),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail(fail[0]), .timeout(tmo[0]),
    .error_count(ecnt[0]), .fail_addr(faddr[0]), .fail_expected(fexp[0]), .fail_actual(fact[0]),
    .writeport_wr(wr[0]), .writeport_addr(waddr[0]), .writeport_data(wdata[0]), .writeport_ack(wack[0]),
    .readport_rd(rd[0]), .readport_addr(raddr[0]), .readport_data(rdata[0]), .readport_ack(rack[0]),
    .state(st[0])
  );

  sdram_bist_engine #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(0), .ADDR_STEP(2),
                      .NUM_WORDS(18), .START_DELAY(3), .TIMEOUT(TMO)) u_dut18 (
    .clk(clk), .rst(rst), .start(start[1]), .mode(mode),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail(fail[1]), .timeout(tmo[1]),
    .error_count(ecnt[1]), .fail_addr(faddr[1]), .fail_expected(fexp[1]), .fail_actual(fact[1]),
    .writeport_wr(wr[1]), .writeport_addr(waddr[1]), .writeport_data(wdata[1]), .writeport_ack(wack[1]),
    .readport_rd(rd[1]), .readport_addr(raddr[1]), .readport_data(rdata[1]), .readport_ack(rack[1]),
    .state(st[1])
  );

  // Memory model: ack one cycle after a request is seen; reads of masked words return corrupt_val
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      wack[g] <= 1'b0;
      rack[g] <= 1'b0;
      if (wr[g] && !wack[g] && !block_wr) begin
        wack[g] <= 1'b1;
        mem[g][waddr[g][5:1]] <= wdata[g];
        wr_log_q.push_back({waddr[g][15:0], wdata[g]});
      end
      if (rd[g] && !rack[g]) begin
        rack[g]  <= 1'b1;
        rdata[g] <= (g == 0 && corrupt_mask[raddr[g][5:1]]) ? corrupt_val : mem[g][raddr[g][5:1]];
      end
    end
  end

  always @(negedge clk) begin
    if ((wr[0] && rd[0]) || (wr[1] && rd[1])) overlap_seen <= 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int sel, input logic [1:0] m);
    @(negedge clk);
    mode = m;
    start[sel] = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done[sel] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, pass, fail, tmo, wr, rd} !== 14'd0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0", {busy, done, pass, fail, tmo, wr, rd});
    end
    checks++;
    if (ecnt[0] !== 16'd0 || faddr[0] !== 32'd0 || fexp[0] !== 16'd0 || fact[0] !== 16'd0) begin
      errors++;
      $display("FAIL reset_capture: ecnt=%h faddr=%h fexp=%h fact=%h want all 0", ecnt[0], faddr[0], fexp[0], fact[0]);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || wr[0] !== 1'b0 || st[0] !== 3'd0) begin
      errors++;
      $display("FAIL reset_no_autorun: busy=%b wr=%b state=%0d want 0/0/0", busy[0], wr[0], st[0]);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_q[$];
    logic [31:0] got, want;
    bit ok;
    wr_log_q.delete();
    overlap_seen = 1'b0;
    pulse_start(0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy[0] !== 1'b1 || wr[0] !== 1'b0) begin
        errors++;
        $display("FAIL basic_delay[%0d]: busy=%b wr=%b want busy=1 wr=0", i, busy[0], wr[0]);
      end
      @(negedge clk);
    end
    wait_done(0, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done_wait: done never rose within 200 cycles"); end
    for (int i = 0; i < 4; i++) exp_q.push_back({16'(2 * i), 16'(i)});
    checks++;
    if (wr_log_q.size() != 4) begin
      errors++;
      $display("FAIL basic_write_count: got %0d want 4", wr_log_q.size());
    end
    while (exp_q.size() > 0 && wr_log_q.size() > 0) begin
      got = wr_log_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL basic_write: got addr/data %h want %h", got, want);
      end
    end
    checks++;
    if (pass[0] !== 1'b1 || fail[0] !== 1'b0 || ecnt[0] !== 16'd0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: pass=%b fail=%b ecnt=%0d busy=%b want 1/0/0/0", pass[0], fail[0], ecnt[0], busy[0]);
    end
    checks++;
    if (overlap_seen !== 1'b0) begin errors++; $display("FAIL basic_overlap: wr and rd high together"); end
  endtask

  task automatic test_mismatch();
    bit ok;
    // word 2 (address 4) reads back 0x00FF
    corrupt_mask = 32'b0100;
    pulse_start(0, 2'd0);
    wait_done(0, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mismatch_done_wait: done never rose"); end
    checks++;
    if (fail[0] !== 1'b1 || pass[0] !== 1'b0 || ecnt[0] !== 16'd1) begin
      errors++;
      $display("FAIL mismatch_result: fail=%b pass=%b ecnt=%0d want 1/0/1", fail[0], pass[0], ecnt[0]);
    end
    checks++;
    if (faddr[0] !== 32'd4 || fexp[0] !== 16'h0002 || fact[0] !== 16'h00FF) begin
      errors++;
      $display("FAIL mismatch_capture: addr=%h exp=%h act=%h want 4/0002/00FF", faddr[0], fexp[0], fact[0]);
    end
    // mode 1, words 1 and 3 corrupted: only the first is captured
    corrupt_mask = 32'b1010;
    wr_log_q.delete();
    pulse_start(0, 2'd1);
    wait_done(0, 200, ok);
    checks++;
    if (!ok || ecnt[0] !== 16'd2 || faddr[0] !== 32'd2 || fexp[0] !== 16'hFFFE || fact[0] !== 16'h00FF) begin
      errors++;
      $display("FAIL mismatch_first_only: ok=%b ecnt=%0d addr=%h exp=%h act=%h want 1/2/2/FFFE/00FF",
               ok, ecnt[0], faddr[0], fexp[0], fact[0]);
    end
    corrupt_mask = 32'd0;
    wr_log_q.delete();
    pulse_start(0, 2'd1);
    wait_done(0, 200, ok);
    checks++;
    if (!ok || pass[0] !== 1'b1 || ecnt[0] !== 16'd0 || faddr[0] !== 32'd0 || fexp[0] !== 16'd0 || fact[0] !== 16'd0) begin
      errors++;
      $display("FAIL mismatch_cleared: ok=%b pass=%b ecnt=%0d addr=%h exp=%h act=%h want 1/1/0/0/0/0",
               ok, pass[0], ecnt[0], faddr[0], fexp[0], fact[0]);
    end
    checks++;
    if (wr_log_q.size() < 1 || wr_log_q[0] !== 32'h0000_FFFF) begin
      errors++;
      $display("FAIL mode1_first_write: got %h want 0000ffff", (wr_log_q.size() > 0) ? wr_log_q[0] : 32'hx);
    end
  endtask

  task automatic test_timeout();
    int hi;
    bit ok;
    block_wr = 1'b1;
    hi = 0;
    ok = 1'b0;
    pulse_start(0, 2'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr[0] === 1'b1) hi++;
      if (done[0] === 1'b1) begin ok = 1'b1; break; end
    end
    block_wr = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_done_wait: done never rose"); end
    checks++;
    if (hi < TMO || hi > TMO + 1) begin
      errors++;
      $display("FAIL timeout_wr_cycles: got %0d want %0d..%0d", hi, TMO, TMO + 1);
    end
    checks++;
    if (tmo[0] !== 1'b1 || fail[0] !== 1'b1 || pass[0] !== 1'b0 || wr[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_result: timeout=%b fail=%b pass=%b wr=%b busy=%b want 1/1/0/0/0",
               tmo[0], fail[0], pass[0], wr[0], busy[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    ok = 1'b0;
    pulse_start(0, 2'd0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (st[0] === 3'd5) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || rd[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_reach_rd_wait: reached=%b rd=%b want 1/1", ok, rd[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rd[0] !== 1'b0 || busy[0] !== 1'b0 || st[0] !== 3'd0) begin
      errors++;
      $display("FAIL midrst_immediate: rd=%b busy=%b state=%0d want 0/0/0", rd[0], busy[0], st[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || wr[0] !== 1'b0 || rd[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: busy=%b wr=%b rd=%b want 0/0/0", busy[0], wr[0], rd[0]);
    end
    wr_log_q.delete();
    pulse_start(0, 2'd0);
    wait_done(0, 200, ok);
    checks++;
    if (!ok || pass[0] !== 1'b1 || wr_log_q.size() != 4) begin
      errors++;
      $display("FAIL midrst_rerun: ok=%b pass=%b writes=%0d want 1/1/4", ok, pass[0], wr_log_q.size());
    end
  endtask

  task automatic test_walking();
    logic [31:0] exp_q[$];
    logic [31:0] got, want;
    logic [15:0] d;
    bit ok;
    wr_log_q.delete();
    pulse_start(1, 2'd2);
    // a second start and a mode change mid-run must both be ignored
    repeat (10) @(negedge clk);
    mode = 2'd1;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    wait_done(1, 500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL walk_done_wait: done never rose"); end
    for (int i = 0; i < 18; i++) begin
      d = 16'd1 << (i % 16);
      exp_q.push_back({16'(2 * i), d});
    end
    checks++;
    if (wr_log_q.size() != 18) begin
      errors++;
      $display("FAIL walk_write_count: got %0d want 18", wr_log_q.size());
    end
    for (int i = 0; i < 18 && wr_log_q.size() > 0; i++) begin
      got = wr_log_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL walk_write[%0d]: got %h want %h", i, got, want);
      end
    end
    checks++;
    if (pass[1] !== 1'b1 || ecnt[1] !== 16'd0) begin
      errors++;
      $display("FAIL walk_result: pass=%b ecnt=%0d want 1/0", pass[1], ecnt[1]);
    end
  endtask

  task automatic test_mode3();
    logic [15:0] exp_d[4];
    bit ok;
`ifdef SDRAM_BIST_LFSR_EN
    exp_d = '{16'h0001, 16'h0003, 16'h0006, 16'h000C};
`else
    exp_d = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
`endif
    wr_log_q.delete();
    pulse_start(0, 2'd3);
    wait_done(0, 200, ok);
    checks++;
    if (!ok || wr_log_q.size() != 4) begin
      errors++;
      $display("FAIL mode3_run: ok=%b writes=%0d want 1/4", ok, wr_log_q.size());
    end
    for (int i = 0; i < 4 && wr_log_q.size() > 0; i++) begin
      checks++;
      if (wr_log_q[0][15:0] !== exp_d[i]) begin
        errors++;
        $display("FAIL mode3_write[%0d]: got %h want %h", i, wr_log_q[0][15:0], exp_d[i]);
      end
      void'(wr_log_q.pop_front());
    end
    checks++;
    if (pass[0] !== 1'b1 || ecnt[0] !== 16'd0) begin
      errors++;
      $display("FAIL mode3_result: pass=%b ecnt=%0d want 1/0", pass[0], ecnt[0]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_timeout();
    test_reset_mid_run();
    test_walking();
    test_mode3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
